mcu_ctrl: RTL and testbench

//  Multi-cycle control unit for the 32-bit MIPS core. Decodes IR and sequences the integer datapath and program counter.

---
 rtl/mcu_pkg.sv | 69 ++++++
 rtl/mcu_if.sv | 39 +++
 rtl/mcu_decode.sv | 47 ++++
 rtl/mcu_ctrl.sv | 137 +++++++++++++
 tb/tb_mcu_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// Holds opcode/funct codes, ALU function codes, mux selects, FSM states and the decode record.
// Contains no logic, so it adds no latency and has no backpressure of its own.
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] FS_PASS_S = 5'd1;
    localparam logic [4:0] FS_ADD    = 5'd2;
    localparam logic [4:0] FS_SUB    = 5'd3;
    localparam logic [4:0] FS_AND    = 5'd4;
    localparam logic [4:0] FS_OR     = 5'd5;
    localparam logic [4:0] FS_SLT    = 5'd6;
    localparam logic [4:0] FS_SLL    = 5'd7;
    localparam logic [4:0] FS_MUL    = 5'd8;

    localparam logic [2:0] Y_SEL_ALU = 3'd0;
    localparam logic [2:0] Y_SEL_HI  = 3'd1;
    localparam logic [2:0] Y_SEL_LO  = 3'd2;
    localparam logic [2:0] Y_SEL_DIN = 3'd3;
    localparam logic [2:0] Y_SEL_PC  = 3'd4;

    localparam logic [1:0] DA_SEL_RD = 2'd0;
    localparam logic [1:0] DA_SEL_RT = 2'd1;
    localparam logic [1:0] DA_SEL_RA = 2'd2;
    localparam logic [1:0] DA_SEL_SP = 2'd3;

    localparam logic [1:0] PC_SEL_BR  = 2'd0;
    localparam logic [1:0] PC_SEL_JMP = 2'd1;
    localparam logic [1:0] PC_SEL_REG = 2'd2;

    typedef enum logic [3:0] {
        RESET, FETCH, DECODE, EXEC, WB, BR, MEM, LWB, HALT, ILLEGAL
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_MFHI, CL_MFLO, CL_MULT, CL_JR,
        CL_BREAK, CL_J, CL_JAL, CL_BEQ, CL_LW, CL_SW
    } inst_class_t;

    typedef struct packed {
        inst_class_t cls;
        logic [4:0]  fs;
        logic        t_sel;
        logic [1:0]  da_sel;
        logic [2:0]  y_sel;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/mcu_if.sv
// Control/status bundle between the control unit and the instruction unit, datapath and data memory.
// Pure wiring: no latency.
// dm_cs/dm_rd/dm_wr are held by the master until dm_ack; no other backpressure.
interface mcu_if;
    logic [31:0] ir;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
    logic        dm_ack;
    logic        pc_inc;
    logic        pc_ld;
    logic [1:0]  pc_sel;
    logic        im_rd;
    logic        ir_ld;
    logic        d_en;
    logic        hilo_ld;
    logic [1:0]  da_sel;
    logic        t_sel;
    logic [2:0]  y_sel;
    logic [4:0]  fs;
    logic        dm_cs;
    logic        dm_rd;
    logic        dm_wr;
    logic        illegal_op;
    logic        halted;

    modport master (
        input  ir, c, v, n, z, dm_ack,
        output pc_inc, pc_ld, pc_sel, im_rd, ir_ld, d_en, hilo_ld, da_sel,
               t_sel, y_sel, fs, dm_cs, dm_rd, dm_wr, illegal_op, halted
    );

    modport slave (
        output ir, c, v, n, z, dm_ack,
        input  pc_inc, pc_ld, pc_sel, im_rd, ir_ld, d_en, hilo_ld, da_sel,
               t_sel, y_sel, fs, dm_cs, dm_rd, dm_wr, illegal_op, halted
    );
endinterface

// File: rtl/mcu_decode.sv
// Instruction decoder: opcode/funct -> class, ALU function, T select, write-back selects, illegal.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is used or latched.
module mcu_decode
    import mcu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);
    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.da_sel = DA_SEL_RD;
                case (funct)
                    FN_ADD:   dec.fs = FS_ADD;
                    FN_SUB:   dec.fs = FS_SUB;
                    FN_AND:   dec.fs = FS_AND;
                    FN_OR:    dec.fs = FS_OR;
                    FN_SLT:   dec.fs = FS_SLT;
                    FN_SLL:   dec.fs = FS_SLL;
                    FN_MULT:  begin dec.cls = CL_MULT; dec.fs = FS_MUL;    end
                    FN_MFHI:  begin dec.cls = CL_MFHI; dec.y_sel = Y_SEL_HI; end
                    FN_MFLO:  begin dec.cls = CL_MFLO; dec.y_sel = Y_SEL_LO; end
                    FN_JR:    begin dec.cls = CL_JR;   dec.fs = FS_PASS_S; end
                    FN_BREAK: dec.cls = CL_BREAK;
                    default:  dec.illegal = 1'b1;
                endcase
            end
            OP_J:    dec.cls = CL_J;
            OP_JAL:  begin dec.cls = CL_JAL; dec.da_sel = DA_SEL_RA; dec.y_sel = Y_SEL_PC; end
            OP_BEQ:  begin dec.cls = CL_BEQ; dec.fs = FS_SUB; end
            OP_ADDI: begin dec.cls = CL_IMM; dec.fs = FS_ADD; dec.t_sel = 1'b1; dec.da_sel = DA_SEL_RT; end
            OP_ORI:  begin dec.cls = CL_IMM; dec.fs = FS_OR;  dec.t_sel = 1'b1; dec.da_sel = DA_SEL_RT; end
            OP_LW:   begin
                dec.cls    = CL_LW;
                dec.fs     = FS_ADD;
                dec.t_sel  = 1'b1;
                dec.da_sel = DA_SEL_RT;
                dec.y_sel  = Y_SEL_DIN;
            end
            OP_SW:   begin dec.cls = CL_SW; dec.fs = FS_ADD; dec.t_sel = 1'b1; end
            default: dec.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/mcu_ctrl.sv
// Multi-cycle MIPS control unit: sequences PC, IR, register file, ALU and data-memory handshake.
// ALU ops 4 cycles, J 2, MULT 3, BEQ 4, SW 3+wait, LW 4+wait (wait = MEM cycles up to MEM_TIMEOUT).
// Stalls in MEM holding dm_cs until dm_ack; traps to ILLEGAL if no ack within MEM_TIMEOUT cycles.
module mcu_ctrl
    import mcu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic  clk,
    input  logic  reset,
    mcu_if.master bus
);
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    dec_t       dec_live;
    dec_t       dec_q;
    dec_t       d;
    logic [7:0] wait_cnt;
    logic       z_q;

    mcu_decode u_decode (
        .opcode (bus.ir[31:26]),
        .funct  (bus.ir[5:0]),
        .dec    (dec_live)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RESET;
            dec_q    <= '0;
            wait_cnt <= '0;
            z_q      <= 1'b0;
        end else begin
            case (state)
                RESET:  state <= FETCH;
                FETCH:  state <= DECODE;
                DECODE: begin
                    dec_q <= dec_live;
                    if (dec_live.illegal)             state <= ILLEGAL;
                    else if (dec_live.cls == CL_J)     state <= FETCH;
                    else if (dec_live.cls == CL_BREAK) state <= HALT;
                    else                               state <= EXEC;
                end
                EXEC: begin
                    wait_cnt <= '0;
                    case (dec_q.cls)
                        CL_MULT:      state <= FETCH;
                        CL_BEQ:       begin z_q <= bus.z; state <= BR; end
                        CL_LW, CL_SW: state <= MEM;
                        default:      state <= WB;
                    endcase
                end
                WB, BR, LWB: state <= FETCH;
                MEM: begin
                    if (bus.dm_ack)             state <= (dec_q.cls == CL_LW) ? LWB : FETCH;
                    else if (wait_cnt == TO_LAST) state <= ILLEGAL;
                    else                          wait_cnt <= wait_cnt + 8'd1;
                end
                HALT:    state <= HALT;
                ILLEGAL: state <= ILLEGAL;
                default: state <= ILLEGAL;
            endcase
        end
    end

    // In DECODE the fields are not latched yet, so the live decode of ir is used.
    always_comb begin
        d              = (state == DECODE) ? dec_live : dec_q;
        bus.pc_inc     = 1'b0;
        bus.pc_ld      = 1'b0;
        bus.pc_sel     = PC_SEL_BR;
        bus.im_rd      = 1'b0;
        bus.ir_ld      = 1'b0;
        bus.d_en       = 1'b0;
        bus.hilo_ld    = 1'b0;
        bus.da_sel     = DA_SEL_RD;
        bus.t_sel      = 1'b0;
        bus.y_sel      = Y_SEL_ALU;
        bus.fs         = 5'd0;
        bus.dm_cs      = 1'b0;
        bus.dm_rd      = 1'b0;
        bus.dm_wr      = 1'b0;
        bus.illegal_op = 1'b0;
        bus.halted     = 1'b0;
        case (state)
            FETCH: begin
                bus.im_rd  = 1'b1;
                bus.ir_ld  = 1'b1;
                bus.pc_inc = 1'b1;
            end
            DECODE: begin
                bus.t_sel = d.t_sel;
                if (d.cls == CL_J) begin
                    bus.pc_ld  = 1'b1;
                    bus.pc_sel = PC_SEL_JMP;
                end
            end
            EXEC: begin
                bus.t_sel   = d.t_sel;
                bus.fs      = d.fs;
                bus.hilo_ld = (d.cls == CL_MULT);
            end
            WB: begin
                if (d.cls == CL_JR) begin
                    bus.pc_ld  = 1'b1;
                    bus.pc_sel = PC_SEL_REG;
                end else begin
                    bus.d_en   = 1'b1;
                    bus.da_sel = d.da_sel;
                    bus.y_sel  = d.y_sel;
                    if (d.cls == CL_JAL) begin
                        bus.pc_ld  = 1'b1;
                        bus.pc_sel = PC_SEL_JMP;
                    end
                end
            end
            BR: begin
                bus.pc_ld  = z_q;
                bus.pc_sel = PC_SEL_BR;
            end
            MEM: begin
                bus.dm_cs = 1'b1;
                bus.dm_rd = (d.cls == CL_LW);
                bus.dm_wr = (d.cls == CL_SW);
            end
            LWB: begin
                bus.d_en   = 1'b1;
                bus.da_sel = DA_SEL_RT;
                bus.y_sel  = Y_SEL_DIN;
            end
            HALT:    bus.halted     = 1'b1;
            ILLEGAL: bus.illegal_op = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mcu_ctrl.sv
// Scoreboard bench for mcu_ctrl: a per-instruction cycle model pushes expected output bundles,
// a negedge monitor pops and compares them against the DUT every cycle.
module tb_mcu_ctrl;
    import mcu_pkg::*;

    localparam int TO = 15;

    typedef struct packed {
        logic       pc_inc;
        logic       pc_ld;
        logic [1:0] pc_sel;
        logic       im_rd;
        logic       ir_ld;
        logic       d_en;
        logic       hilo_ld;
        logic [1:0] da_sel;
        logic       t_sel;
        logic [2:0] y_sel;
        logic [4:0] fs;
        logic       dm_cs;
        logic       dm_rd;
        logic       dm_wr;
        logic       illegal_op;
        logic       halted;
    } ov_t;

    localparam int K_ALU = 0, K_IMM = 1, K_MFHI = 2, K_MFLO = 3, K_MULT = 4, K_JR = 5,
                   K_BRK = 6, K_J = 7, K_JAL = 8, K_BEQ = 9, K_LW = 10, K_SW = 11, K_ILL = 12;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    mcu_if bus ();

    ov_t   exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;
    ov_t   act;
    ov_t   mon_e;
    string mon_t;

    mcu_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign act = {bus.pc_inc, bus.pc_ld, bus.pc_sel, bus.im_rd, bus.ir_ld, bus.d_en, bus.hilo_ld,
                  bus.da_sel, bus.t_sel, bus.y_sel, bus.fs, bus.dm_cs, bus.dm_rd, bus.dm_wr,
                  bus.illegal_op, bus.halted};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                failures++;
                $display("FAIL %s t=%0t got=%06h expected=%06h", mon_t, $time, act, mon_e);
            end
        end
    end

    task automatic push(input ov_t v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    // Instruction table: class, ALU function and whether T comes from the immediate.
    task automatic classify(input logic [31:0] ins, output int k, output logic [4:0] f, output bit imm);
        f = 5'd0; imm = 1'b0; k = K_ILL;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: begin k = K_ALU;  f = FS_ADD; end
                6'h22: begin k = K_ALU;  f = FS_SUB; end
                6'h24: begin k = K_ALU;  f = FS_AND; end
                6'h25: begin k = K_ALU;  f = FS_OR;  end
                6'h2A: begin k = K_ALU;  f = FS_SLT; end
                6'h00: begin k = K_ALU;  f = FS_SLL; end
                6'h18: begin k = K_MULT; f = FS_MUL; end
                6'h10: k = K_MFHI;
                6'h12: k = K_MFLO;
                6'h08: begin k = K_JR; f = FS_PASS_S; end
                6'h0D: k = K_BRK;
                default: k = K_ILL;
            endcase
            6'h02: k = K_J;
            6'h03: k = K_JAL;
            6'h04: begin k = K_BEQ; f = FS_SUB; end
            6'h08: begin k = K_IMM; f = FS_ADD; imm = 1'b1; end
            6'h0D: begin k = K_IMM; f = FS_OR;  imm = 1'b1; end
            6'h23: begin k = K_LW;  f = FS_ADD; imm = 1'b1; end
            6'h2B: begin k = K_SW;  f = FS_ADD; imm = 1'b1; end
            default: k = K_ILL;
        endcase
    endtask

    // Pushes the full expected cycle trace of one instruction starting in FETCH.
    task automatic model(input logic [31:0] ins, input bit zv, input int ack_at,
                         output int n, output bit term);
        int k; logic [4:0] f; bit imm; ov_t o; string nm;
        classify(ins, k, f, imm);
        nm = $sformatf("%08h", ins);
        n = 0; term = 1'b0;
        o = '0; o.pc_inc = 1; o.im_rd = 1; o.ir_ld = 1;
        push(o, {nm, ".fetch"}); n++;
        o = '0; o.t_sel = imm;
        if (k == K_J) begin o.pc_ld = 1; o.pc_sel = 2'd1; end
        push(o, {nm, ".decode"}); n++;
        if (k == K_J) return;
        if (k == K_BRK || k == K_ILL) begin
            o = '0; o.halted = (k == K_BRK); o.illegal_op = (k == K_ILL);
            repeat (3) begin push(o, {nm, ".trap"}); n++; end
            term = 1'b1;
            return;
        end
        o = '0; o.t_sel = imm; o.fs = f; o.hilo_ld = (k == K_MULT);
        push(o, {nm, ".exec"}); n++;
        if (k == K_MULT) return;
        if (k == K_BEQ) begin
            o = '0; o.pc_ld = zv; o.pc_sel = 2'd0;
            push(o, {nm, ".br"}); n++;
            return;
        end
        if (k == K_LW || k == K_SW) begin
            o = '0; o.dm_cs = 1; o.dm_rd = (k == K_LW); o.dm_wr = (k == K_SW);
            for (int i = 0; i < TO && i <= ack_at; i++) begin push(o, {nm, ".mem"}); n++; end
            if (ack_at >= TO) begin
                o = '0; o.illegal_op = 1;
                repeat (3) begin push(o, {nm, ".timeout"}); n++; end
                term = 1'b1;
            end else if (k == K_LW) begin
                o = '0; o.d_en = 1; o.da_sel = 2'd1; o.y_sel = 3'd3;
                push(o, {nm, ".lwb"}); n++;
            end
            return;
        end
        o = '0;
        case (k)
            K_ALU:  begin o.d_en = 1; o.da_sel = 2'd0; o.y_sel = 3'd0; end
            K_IMM:  begin o.d_en = 1; o.da_sel = 2'd1; o.y_sel = 3'd0; end
            K_MFHI: begin o.d_en = 1; o.da_sel = 2'd0; o.y_sel = 3'd1; end
            K_MFLO: begin o.d_en = 1; o.da_sel = 2'd0; o.y_sel = 3'd2; end
            K_JAL:  begin o.d_en = 1; o.da_sel = 2'd2; o.y_sel = 3'd4; o.pc_ld = 1; o.pc_sel = 2'd1; end
            K_JR:   begin o.pc_ld = 1; o.pc_sel = 2'd2; end
            default: ;
        endcase
        push(o, {nm, ".wb"}); n++;
    endtask

    task automatic drive_cycle(input int c, input logic [31:0] ins, input bit zv, input int ack_at, input bit is_mem);
        bus.ir = (c == 1) ? ins : 32'($urandom);
        bus.z  = (c == 2) ? zv : 1'($urandom_range(0, 1));
        bus.c  = 1'($urandom_range(0, 1));
        bus.v  = 1'($urandom_range(0, 1));
        bus.n  = 1'($urandom_range(0, 1));
        if (is_mem && c >= 3 && (c - 3) <= ack_at && (c - 3) < TO)
            bus.dm_ack = ((c - 3) == ack_at);
        else
            bus.dm_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) push('0, "reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [31:0] ins, input bit zv, input int ack_at);
        int n; bit term; bit is_mem;
        model(ins, zv, ack_at, n, term);
        is_mem = (ins[31:26] == 6'h23) || (ins[31:26] == 6'h2B);
        for (int c = 0; c < n; c++) begin
            drive_cycle(c, ins, zv, ack_at, is_mem);
            @(posedge clk); #1;
        end
        if (term) do_reset();
    endtask

    // Reset asserted in the middle of a store must drop the memory strobes without waiting for a clock.
    task automatic abort_mem();
        int n; bit term;
        model(32'hAD090004, 1'b0, TO, n, term);
        for (int c = 0; c < 5; c++) begin
            drive_cycle(c, 32'hAD090004, 1'b0, TO, 1'b1);
            @(posedge clk); #1;
        end
        bus.dm_ack = 1'b0;
        #1;
        checks++;
        if (!(bus.dm_cs && bus.dm_wr)) begin
            failures++;
            $display("FAIL abort.pre got cs=%0b wr=%0b expected cs=1 wr=1", bus.dm_cs, bus.dm_wr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.dm_cs || bus.dm_rd || bus.dm_wr) begin
            failures++;
            $display("FAIL abort.async got cs=%0b rd=%0b wr=%0b expected 0", bus.dm_cs, bus.dm_rd, bus.dm_wr);
        end
        exp_q.delete();
        tag_q.delete();
        do_reset();
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 21);
        case (k)
            0:  rand_ins = {6'h00, r[25:6], FN_ADD};
            1:  rand_ins = {6'h00, r[25:6], FN_SUB};
            2:  rand_ins = {6'h00, r[25:6], FN_AND};
            3:  rand_ins = {6'h00, r[25:6], FN_OR};
            4:  rand_ins = {6'h00, r[25:6], FN_SLT};
            5:  rand_ins = {6'h00, r[25:6], FN_SLL};
            6:  rand_ins = {6'h00, r[25:6], FN_MULT};
            7:  rand_ins = {6'h00, r[25:6], FN_MFHI};
            8:  rand_ins = {6'h00, r[25:6], FN_MFLO};
            9:  rand_ins = {6'h00, r[25:6], FN_JR};
            10: rand_ins = {OP_J,    r[25:0]};
            11: rand_ins = {OP_JAL,  r[25:0]};
            12, 13: rand_ins = {OP_BEQ, r[25:0]};
            14: rand_ins = {OP_ADDI, r[25:0]};
            15: rand_ins = {OP_ORI,  r[25:0]};
            16, 17: rand_ins = {OP_LW, r[25:0]};
            18, 19: rand_ins = {OP_SW, r[25:0]};
            20: rand_ins = (r[0]) ? {6'h00, r[25:6], FN_BREAK} : {6'h00, r[25:6], 6'h3F};
            default: rand_ins = {6'h3F, r[25:0]};
        endcase
    endfunction

    initial begin
        bus.ir = 'x;
        bus.c = 1'b0; bus.v = 1'b0; bus.n = 1'b0; bus.z = 1'b0; bus.dm_ack = 1'b0;
        @(posedge clk); #1;
        do_reset();
        run(32'h012A4020, 1'b0, 0);
        run(32'h8D090004, 1'b0, 2);
        run(32'hAD090004, 1'b0, TO);
        run(32'h11090003, 1'b1, 0);
        run(32'h11090003, 1'b0, 0);
        run(32'h0C000040, 1'b0, 0);
        run(32'h0000000D, 1'b0, 0);
        run(32'hFC000000, 1'b0, 0);
        run(32'hAD090004, 1'b0, 0);
        run(32'h8D090004, 1'b0, TO - 1);
        run(32'h01090018, 1'b0, 0);
        run(32'h00004010, 1'b0, 0);
        run(32'h03E00008, 1'b0, 0);
        run(32'h08000010, 1'b0, 0);
        run(32'h000A4100, 1'b0, 0);
        abort_mem();
        for (int i = 0; i < 250; i++)
            run(rand_ins(), 1'($urandom_range(0, 1)), int'($urandom_range(0, TO)));
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard.drain got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
